// File: rtl/pc_unit_if.sv
// Bundle between the control/branch-compare logic and the PC unit.
// master: control side (drives redirect requests), slave: pc_unit.
interface pc_unit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             stall_i;
   logic             br_taken_i;
   logic             jalr_i;
   logic [XLEN-1:0]  imm_i;
   logic [XLEN-1:0]  rs1_i;
   logic [XLEN-1:0]  pc_o;
   logic [XLEN-1:0]  pc_plus_o;
   logic             misalign_o;
   logic [XLEN-1:0]  bad_addr_o;
   logic [CNT_W-1:0] retired_o;

   modport master (
      output stall_i, br_taken_i, jalr_i, imm_i, rs1_i,
      input  pc_o, pc_plus_o, misalign_o, bad_addr_o, retired_o
   );

   modport slave (
      input  stall_i, br_taken_i, jalr_i, imm_i, rs1_i,
      output pc_o, pc_plus_o, misalign_o, bad_addr_o, retired_o
   );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC select (JALR > branch > sequential),
// link value and retired-instruction counter.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_EN.
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter int              INC          = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0000_0100,
   parameter int              CNT_W        = 32
) (
   input logic clk,
   input logic rst,
   pc_unit_if.slave bus
);

   localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  seq_tgt, br_tgt, jalr_tgt, tgt;
   logic             redirect;

   assign seq_tgt  = pc_q + INC_V;
   assign br_tgt   = pc_q + bus.imm_i;
   assign jalr_tgt = (bus.rs1_i + bus.imm_i) & ~XLEN'(1);

   // Next-PC select; JALR outranks branch when both are raised.
   always_comb begin
      tgt      = seq_tgt;
      redirect = 1'b0;
      if (bus.jalr_i) begin
         tgt      = jalr_tgt;
         redirect = 1'b1;
      end else if (bus.br_taken_i) begin
         tgt      = br_tgt;
         redirect = 1'b1;
      end
   end

`ifdef PC_MISALIGN_EN
   logic            trap;
   logic            misalign_q;
   logic [XLEN-1:0] bad_addr_q;

   // Only redirect targets are checked; sequential targets are aligned by construction of INC.
   assign trap = ~bus.stall_i & redirect & (tgt[1:0] != 2'b00);
   assign pc_d = trap ? TRAP_VECTOR : tgt;

   // Trap status: pulse for one cycle, faulting address held until the next trap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_q <= 1'b0;
         bad_addr_q <= '0;
      end else begin
         misalign_q <= trap;
         if (trap)
            bad_addr_q <= tgt;
      end
   end

   assign bus.misalign_o = misalign_q;
   assign bus.bad_addr_o = bad_addr_q;
`else
   logic [XLEN-1:0] unused_trap_vector;
   logic            unused_redirect;

   assign unused_trap_vector = TRAP_VECTOR;
   assign unused_redirect    = redirect;
   assign pc_d               = tgt;
   assign bus.misalign_o     = 1'b0;
   assign bus.bad_addr_o     = '0;
`endif

   // PC and retired counter advance together on every non-stalled edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= RESET_VECTOR;
         cnt_q <= '0;
      end else if (!bus.stall_i) begin
         pc_q  <= pc_d;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.pc_o      = pc_q;
   assign bus.pc_plus_o = seq_tgt;
   assign bus.retired_o = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_mis;
   int   exp_ret;

   pc_unit_if #(.XLEN(32), .CNT_W(32)) bus_if ();

   pc_unit #(
      .XLEN(32), .INC(4), .RESET_VECTOR(32'h0000_0000),
      .TRAP_VECTOR(32'h0000_0100), .CNT_W(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic br, input logic jr,
                        input logic [31:0] imm, input logic [31:0] rs1);
      bus_if.stall_i    = st;
      bus_if.br_taken_i = br;
      bus_if.jalr_i     = jr;
      bus_if.imm_i      = imm;
      bus_if.rs1_i      = rs1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      step();
      n_cmp++;
      if (bus_if.pc_o !== 32'h0) begin
         $display("FAIL reset_pc got %h want %h", bus_if.pc_o, 32'h0); n_mis++;
      end
      n_cmp++;
      if (bus_if.retired_o !== 32'h0) begin
         $display("FAIL reset_retired got %h want %h", bus_if.retired_o, 32'h0); n_mis++;
      end
      n_cmp++;
      if (bus_if.misalign_o !== 1'b0) begin
         $display("FAIL reset_misalign got %b want 0", bus_if.misalign_o); n_mis++;
      end
      n_cmp++;
      if (bus_if.bad_addr_o !== 32'h0) begin
         $display("FAIL reset_bad_addr got %h want %h", bus_if.bad_addr_o, 32'h0); n_mis++;
      end
      rst = 1'b0;
      exp_ret = 0;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         exp_ret++;
         n_cmp++;
         if (bus_if.pc_o !== exp_pc[i]) begin
            $display("FAIL seq_pc[%0d] got %h want %h", i, bus_if.pc_o, exp_pc[i]); n_mis++;
         end
      end
      n_cmp++;
      if (bus_if.retired_o !== 32'd3) begin
         $display("FAIL seq_retired got %0d want 3", bus_if.retired_o); n_mis++;
      end
      n_cmp++;
      if (bus_if.pc_plus_o !== 32'h10) begin
         $display("FAIL seq_pc_plus got %h want %h", bus_if.pc_plus_o, 32'h10); n_mis++;
      end
   endtask

   task automatic test_branch_priority();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(); exp_ret++;
      n_cmp++;
      if (bus_if.pc_o !== 32'h10) begin
         $display("FAIL pre_branch_pc got %h want %h", bus_if.pc_o, 32'h10); n_mis++;
      end
      drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
      step(); exp_ret++;
      n_cmp++;
      if (bus_if.pc_o !== 32'h8) begin
         $display("FAIL branch_back_pc got %h want %h", bus_if.pc_o, 32'h8); n_mis++;
      end
      drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h101);
      step(); exp_ret++;
      n_cmp++;
      if (bus_if.pc_o !== 32'h100) begin
         $display("FAIL jalr_wins_pc got %h want %h", bus_if.pc_o, 32'h100); n_mis++;
      end
      n_cmp++;
      if (bus_if.retired_o !== exp_ret) begin
         $display("FAIL branch_retired got %0d want %0d", bus_if.retired_o, exp_ret); n_mis++;
      end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b0, 1'b1, 32'hC, 32'hFFFF_FFF0);
      step(); exp_ret++;
      n_cmp++;
      if (bus_if.pc_o !== 32'hFFFF_FFFC) begin
         $display("FAIL wrap_jalr_pc got %h want %h", bus_if.pc_o, 32'hFFFF_FFFC); n_mis++;
      end
      n_cmp++;
      if (bus_if.pc_plus_o !== 32'h0) begin
         $display("FAIL wrap_pc_plus got %h want %h", bus_if.pc_plus_o, 32'h0); n_mis++;
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(); exp_ret++;
      n_cmp++;
      if (bus_if.pc_o !== 32'h0) begin
         $display("FAIL wrap_seq_pc got %h want %h", bus_if.pc_o, 32'h0); n_mis++;
      end
   endtask

   task automatic test_stall();
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h20);
      step(); exp_ret++;
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (bus_if.pc_o !== 32'h20) begin
            $display("FAIL stall_pc[%0d] got %h want %h", i, bus_if.pc_o, 32'h20); n_mis++;
         end
         n_cmp++;
         if (bus_if.retired_o !== exp_ret) begin
            $display("FAIL stall_retired[%0d] got %0d want %0d", i, bus_if.retired_o, exp_ret); n_mis++;
         end
      end
      n_cmp++;
      if (bus_if.pc_plus_o !== 32'h24) begin
         $display("FAIL stall_pc_plus got %h want %h", bus_if.pc_plus_o, 32'h24); n_mis++;
      end
      n_cmp++;
      if (bus_if.misalign_o !== 1'b0) begin
         $display("FAIL stall_misalign got %b want 0", bus_if.misalign_o); n_mis++;
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(); exp_ret++;
      n_cmp++;
      if (bus_if.pc_o !== 32'h24) begin
         $display("FAIL stall_release_pc got %h want %h", bus_if.pc_o, 32'h24); n_mis++;
      end
      n_cmp++;
      if (bus_if.retired_o !== exp_ret) begin
         $display("FAIL stall_release_retired got %0d want %0d", bus_if.retired_o, exp_ret); n_mis++;
      end
   endtask

   task automatic test_misalign();
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h40);
      step(); exp_ret++;
      drive(1'b0, 1'b1, 1'b0, 32'h2, 32'h0);
      step(); exp_ret++;
`ifdef PC_MISALIGN_EN
      n_cmp++;
      if (bus_if.pc_o !== 32'h100) begin
         $display("FAIL mis_trap_pc got %h want %h", bus_if.pc_o, 32'h100); n_mis++;
      end
      n_cmp++;
      if (bus_if.bad_addr_o !== 32'h42) begin
         $display("FAIL mis_bad_addr got %h want %h", bus_if.bad_addr_o, 32'h42); n_mis++;
      end
      n_cmp++;
      if (bus_if.misalign_o !== 1'b1) begin
         $display("FAIL mis_pulse got %b want 1", bus_if.misalign_o); n_mis++;
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(); exp_ret++;
      n_cmp++;
      if (bus_if.misalign_o !== 1'b0) begin
         $display("FAIL mis_pulse_end got %b want 0", bus_if.misalign_o); n_mis++;
      end
      n_cmp++;
      if (bus_if.pc_o !== 32'h104) begin
         $display("FAIL mis_after_pc got %h want %h", bus_if.pc_o, 32'h104); n_mis++;
      end
      n_cmp++;
      if (bus_if.bad_addr_o !== 32'h42) begin
         $display("FAIL mis_bad_hold got %h want %h", bus_if.bad_addr_o, 32'h42); n_mis++;
      end
`else
      n_cmp++;
      if (bus_if.pc_o !== 32'h42) begin
         $display("FAIL nomis_pc got %h want %h", bus_if.pc_o, 32'h42); n_mis++;
      end
      n_cmp++;
      if (bus_if.misalign_o !== 1'b0) begin
         $display("FAIL nomis_misalign got %b want 0", bus_if.misalign_o); n_mis++;
      end
      n_cmp++;
      if (bus_if.bad_addr_o !== 32'h0) begin
         $display("FAIL nomis_bad_addr got %h want %h", bus_if.bad_addr_o, 32'h0); n_mis++;
      end
      // JALR clears only bit 0; bit 1 survives.
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h103);
      step(); exp_ret++;
      n_cmp++;
      if (bus_if.pc_o !== 32'h102) begin
         $display("FAIL jalr_bit1_pc got %h want %h", bus_if.pc_o, 32'h102); n_mis++;
      end
`endif
      n_cmp++;
      if (bus_if.retired_o !== exp_ret) begin
         $display("FAIL mis_retired got %0d want %0d", bus_if.retired_o, exp_ret); n_mis++;
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h30);
      step(); exp_ret++;
      n_cmp++;
      if (bus_if.pc_o !== 32'h30) begin
         $display("FAIL pre_rst_pc got %h want %h", bus_if.pc_o, 32'h30); n_mis++;
      end
      drive(1'b0, 1'b1, 1'b0, 32'h2, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus_if.pc_o !== 32'h0) begin
         $display("FAIL async_rst_pc got %h want %h", bus_if.pc_o, 32'h0); n_mis++;
      end
      n_cmp++;
      if (bus_if.retired_o !== 32'h0) begin
         $display("FAIL async_rst_retired got %h want %h", bus_if.retired_o, 32'h0); n_mis++;
      end
      step();
      n_cmp++;
      if (bus_if.pc_o !== 32'h0) begin
         $display("FAIL rst_held_pc got %h want %h", bus_if.pc_o, 32'h0); n_mis++;
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      n_cmp++;
      if (bus_if.pc_o !== 32'h4) begin
         $display("FAIL post_rst_pc got %h want %h", bus_if.pc_o, 32'h4); n_mis++;
      end
      n_cmp++;
      if (bus_if.retired_o !== 32'd1) begin
         $display("FAIL post_rst_retired got %0d want 1", bus_if.retired_o); n_mis++;
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_mis   = 0;
      exp_ret = 0;
      rst     = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      test_reset();
      test_sequential();
      test_branch_priority();
      test_wrap();
      test_stall();
      test_misalign();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
